// File: rtl/seq_sub_16_bit_if.sv
// Start/busy/done handshake and operand/result bus for the sequential subtractor.
// Flag signals zero/ovf exist only when SUB_FLAGS_EN is defined.
interface seq_sub_16_bit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/seq_sub_16_bit.sv
// Multi-cycle subtractor: diff = a - b - bin, one BITS_PER_CYCLE slice per clock.
// Optional zero/ovf flags are built when SUB_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, result registers hold last result
// BUSY  | processing one slice per cycle, N cycles total
// DONE  | one-cycle done pulse, then back to IDLE
module seq_sub_16_bit #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_sub_16_bit_if.slave   bus
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = WIDTH / BPC;
    localparam int CW  = $clog2(N) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic [BPC:0]     slice_d;
    logic [WIDTH-1:0] res_d;
    logic             last_d;

`ifdef SUB_FLAGS_EN
    logic             zero_q;
    logic             ovf_q;
    logic             a_msb_q;
    logic             b_msb_q;
`endif

    always_comb begin
        slice_d = {1'b0, a_q[BPC-1:0]} - {1'b0, b_q[BPC-1:0]} - (BPC+1)'(borrow_q);
        // new slice enters at the MSB end; after N shifts slice 0 sits at bit 0
        res_d   = (res_q >> BPC) | (WIDTH'(slice_d[BPC-1:0]) << (WIDTH - BPC));
        last_d  = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_BUSY;
`ifdef SUB_FLAGS_EN
                        a_msb_q  <= bus.a[WIDTH-1];
                        b_msb_q  <= bus.b[WIDTH-1];
`endif
                    end
                end
                S_BUSY: begin
                    a_q      <= a_q >> BPC;
                    b_q      <= b_q >> BPC;
                    borrow_q <= slice_d[BPC];
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        diff_q  <= res_d;
                        bout_q  <= slice_d[BPC];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`ifdef SUB_FLAGS_EN
                        zero_q  <= (res_d == '0);
                        // operands of opposite sign and result sign differs from minuend
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUB_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_16_bit.sv
// Scoreboard bench for seq_sub_16_bit: 1-bit slice instance for the main checks,
// plus 4- and 16-bit slice instances for latency and result checks.
module tb_seq_sub_16_bit;
    localparam int N = 16;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   m_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_done = 0;
    exp_t sb[$];

    seq_sub_16_bit_if #(.WIDTH(16)) sub_if ();
    seq_sub_16_bit_if #(.WIDTH(16)) if4 ();
    seq_sub_16_bit_if #(.WIDTH(16)) if16 ();

    seq_sub_16_bit #(.WIDTH(16), .BITS_PER_CYCLE(1))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(sub_if));
    seq_sub_16_bit #(.WIDTH(16), .BITS_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_sub_16_bit #(.WIDTH(16), .BITS_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin, input int c);
        exp_t        e;
        logic [16:0] full;
        int          sd;
        full   = {1'b0, a} - {1'b0, b} - 17'(bin);
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.diff = full[15:0];
        e.bout = full[16];
        e.zero = (full[15:0] == 16'h0);
        e.ovf  = (sd < -32768) || (sd > 32767);
        e.acc  = c;
        return e;
    endfunction

    // reference handshake: accept only when idle, then N busy cycles and one done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            sb.delete();
        end else if (m_cnt == 0) begin
            if (sub_if.start) begin
                sb.push_back(model(sub_if.a, sub_if.b, sub_if.bin, cyc));
                n_acc <= n_acc + 1;
                m_cnt <= N + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && sub_if.done) begin
            exp_t e;
            n_done++;
            chk("busy_with_done", {31'b0, sub_if.busy}, 32'd0);
            chk("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("diff", {16'b0, sub_if.diff}, {16'b0, e.diff});
                chk("bout", {31'b0, sub_if.bout}, {31'b0, e.bout});
                chk("latency", cyc - e.acc - 1, N);
`ifdef SUB_FLAGS_EN
                chk("zero", {31'b0, sub_if.zero}, {31'b0, e.zero});
                chk("ovf", {31'b0, sub_if.ovf}, {31'b0, e.ovf});
`endif
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || m_cnt != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", {31'b0, (k < 200)}, 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.a     = a;
        sub_if.b     = b;
        sub_if.bin   = bin;
        @(negedge clk);
        sub_if.start = 1'b0;
        sub_if.a     = 16'($urandom);
        sub_if.b     = 16'($urandom);
        sub_if.bin   = 1'($urandom);
        wait_idle();
    endtask

    initial begin
        int          lat4;
        int          lat16;
        logic [15:0] d4;
        logic [15:0] d16;
        logic        bo4;
        logic        bo16;
        logic        ov4;
        logic        ov16;

        rst_n = 1'b0;
        sub_if.start = 1'b0; sub_if.a = '0; sub_if.b = '0; sub_if.bin = 1'b0;
        if4.start    = 1'b0; if4.a    = '0; if4.b    = '0; if4.bin    = 1'b0;
        if16.start   = 1'b0; if16.a   = '0; if16.b   = '0; if16.bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, sub_if.busy}, 32'd0);
        chk("rst_done", {31'b0, sub_if.done}, 32'd0);
        chk("rst_diff", {16'b0, sub_if.diff}, 32'd0);
        chk("rst_bout", {31'b0, sub_if.bout}, 32'd0);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0234, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b1);
        do_op(16'h0005, 16'h0005, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom));

        // start held high with operands changing every cycle
        @(negedge clk);
        sub_if.start = 1'b1;
        repeat (3 * (N + 2) + 1) begin
            sub_if.a   = 16'($urandom);
            sub_if.b   = 16'($urandom);
            sub_if.bin = 1'($urandom);
            @(negedge clk);
        end
        sub_if.start = 1'b0;
        wait_idle();
        chk("done_count", n_done, n_acc);

        // reset during the 7th busy cycle
        do_op(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.a     = 16'h4321;
        sub_if.b     = 16'h1111;
        @(negedge clk);
        sub_if.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, sub_if.busy}, 32'd0);
        chk("abort_done", {31'b0, sub_if.done}, 32'd0);
        chk("abort_diff", {16'b0, sub_if.diff}, 32'd0);
        chk("abort_bout", {31'b0, sub_if.bout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("abort_no_done", n_done, n_acc - 1);
        do_op(16'h4321, 16'h1111, 1'b0);

        // wider slices
        lat4 = -1; lat16 = -1;
        d4 = '0; d16 = '0; bo4 = 1'b0; bo16 = 1'b0; ov4 = 1'b0; ov16 = 1'b0;
        @(negedge clk);
        if4.start  = 1'b1; if4.a  = 16'hA5A5; if4.b  = 16'h5A5A; if4.bin  = 1'b0;
        if16.start = 1'b1; if16.a = 16'hA5A5; if16.b = 16'h5A5A; if16.bin = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if4.start = 1'b0;  if4.a  = 16'h1111;
                if16.start = 1'b0; if16.a = 16'h1111;
            end
            if (if4.done && lat4 < 0) begin
                lat4 = k - 1; d4 = if4.diff; bo4 = if4.bout;
`ifdef SUB_FLAGS_EN
                ov4 = if4.ovf;
`endif
            end
            if (if16.done && lat16 < 0) begin
                lat16 = k - 1; d16 = if16.diff; bo16 = if16.bout;
`ifdef SUB_FLAGS_EN
                ov16 = if16.ovf;
`endif
            end
        end
        chk("bpc4_latency", lat4, 4);
        chk("bpc4_diff", {16'b0, d4}, 32'h4B4B);
        chk("bpc4_bout", {31'b0, bo4}, 32'd0);
        chk("bpc16_latency", lat16, 1);
        chk("bpc16_diff", {16'b0, d16}, 32'h4B4B);
        chk("bpc16_bout", {31'b0, bo16}, 32'd0);
`ifdef SUB_FLAGS_EN
        chk("bpc4_ovf", {31'b0, ov4}, 32'd1);
        chk("bpc16_ovf", {31'b0, ov16}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
